// File: rtl/systolic_array_ctrl.sv
// Job sequencer between a host operand/result stream and one systolic_array:
// buffers a job, clears the array, bursts the operands, captures and streams back the rows.
module systolic_array_ctrl #(
    parameter int DATAWIDTH    = 16,
    parameter int N_SIZE       = 5,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_SIZE*DATAWIDTH-1:0]     in_a,
    input  logic [N_SIZE*DATAWIDTH-1:0]     in_b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [N_SIZE*2*DATAWIDTH-1:0]   out_row,
    output logic                            out_last,
    output logic                            busy,
    output logic                            err,
    output logic                            arr_rst_n,
    output logic                            arr_valid_in,
    output logic [N_SIZE*DATAWIDTH-1:0]     arr_a,
    output logic [N_SIZE*DATAWIDTH-1:0]     arr_b,
    input  logic                            arr_valid_out,
    input  logic [N_SIZE*2*DATAWIDTH-1:0]   arr_c
);
    localparam int AW = N_SIZE * DATAWIDTH;
    localparam int RW = N_SIZE * 2 * DATAWIDTH;
    localparam int CW = (N_SIZE > 1) ? $clog2(N_SIZE) : 1;
    localparam int WW = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST      = CW'(N_SIZE - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_FEED    = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;
    localparam logic [2:0] S_OUTPUT  = 3'd6;

    logic [2:0]    state;
    logic [CW-1:0] idx;
    logic [CW-1:0] idx_next;
    logic [WW-1:0] wait_cnt;

    logic [AW-1:0] buf_a [N_SIZE];
    logic [AW-1:0] buf_b [N_SIZE];
    logic [RW-1:0] res   [N_SIZE];

    assign idx_next = idx + 1'b1;
    assign busy     = (state != S_IDLE);

    // One index serves beat count, feed slot, capture row and output row: the phases never overlap.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && in_valid && in_ready) begin
            buf_a[idx] <= in_a;
            buf_b[idx] <= in_b;
        end
    end

    // Row 0 is taken in WAIT on the first valid_out sample, rows 1.. in CAPTURE.
    always_ff @(posedge clk) begin
        if ((state == S_WAIT && arr_valid_out) || state == S_CAPTURE) begin
            res[idx] <= arr_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            idx          <= '0;
            wait_cnt     <= '0;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_row      <= '0;
            err          <= 1'b0;
            arr_rst_n    <= 1'b0;
            arr_valid_in <= 1'b0;
            arr_a        <= '0;
            arr_b        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    arr_rst_n <= 1'b1;
                    if (in_valid && in_ready) begin
                        err <= 1'b0;
                        if (idx == LAST) begin
                            idx       <= '0;
                            in_ready  <= 1'b0;
                            arr_rst_n <= 1'b0;
                            state     <= S_CLEAR;
                        end else begin
                            idx      <= idx_next;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    arr_rst_n    <= 1'b1;
                    arr_valid_in <= 1'b1;
                    arr_a        <= buf_a[0];
                    arr_b        <= buf_b[0];
                    idx          <= '0;
                    state        <= S_FEED;
                end
                S_FEED: begin
                    if (idx == LAST) begin
                        arr_valid_in <= 1'b0;
                        arr_a        <= '0;
                        arr_b        <= '0;
                        idx          <= '0;
                        wait_cnt     <= '0;
                        state        <= S_WAIT;
                    end else begin
                        idx   <= idx_next;
                        arr_a <= buf_a[idx_next];
                        arr_b <= buf_b[idx_next];
                    end
                end
                S_WAIT: begin
                    if (arr_valid_out) begin
                        idx      <= CW'(1);
                        wait_cnt <= '0;
                        state    <= S_CAPTURE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err       <= 1'b1;
                        arr_rst_n <= 1'b0;
                        in_ready  <= 1'b1;
                        idx       <= '0;
                        wait_cnt  <= '0;
                        state     <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= S_DRAIN;
                    end else begin
                        idx <= idx_next;
                    end
                end
                S_DRAIN: begin
                    if (!arr_valid_out) begin
                        out_valid <= 1'b1;
                        out_row   <= res[0];
                        out_last  <= 1'b0;
                        idx       <= '0;
                        state     <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        if (idx == LAST) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_row   <= '0;
                            idx       <= '0;
                            in_ready  <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            idx      <= idx_next;
                            out_row  <= res[idx_next];
                            out_last <= (idx_next == LAST);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl with a small behavioural array model
// (accumulating outer products, cleared only by arr_rst_n).
module tb_systolic_array_ctrl;
    localparam int DW = 16;
    localparam int N  = 2;
    localparam int WT = 64;
    localparam int AW = N * DW;
    localparam int RW = N * 2 * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_a = '0;
    logic [AW-1:0] in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] out_row;
    logic          out_last;
    logic          busy;
    logic          err;
    logic          arr_rst_n;
    logic          arr_valid_in;
    logic [AW-1:0] arr_a;
    logic [AW-1:0] arr_b;
    logic          arr_valid_out = 1'b0;
    logic [RW-1:0] arr_c = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    systolic_array_ctrl #(
        .DATAWIDTH(DW),
        .N_SIZE(N),
        .WAIT_TIMEOUT(WT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_row(out_row),
        .out_last(out_last),
        .busy(busy),
        .err(err),
        .arr_rst_n(arr_rst_n),
        .arr_valid_in(arr_valid_in),
        .arr_a(arr_a),
        .arr_b(arr_b),
        .arr_valid_out(arr_valid_out),
        .arr_c(arr_c)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Array model: results appear 2 cycles after the last beat, followed by one junk valid row.
    int acc [N][N];
    int oc = 0;
    int beats = 0;
    logic tie_off = 1'b0;
    logic [RW-1:0] mrow;
    always @(posedge clk) begin
        if (!arr_rst_n) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    acc[i][j] = 0;
            oc = 0;
            beats = 0;
            arr_valid_out <= 1'b0;
            arr_c <= '0;
        end else begin
            if (oc > 0) begin
                oc++;
                if (oc >= 3 && oc < 3 + N) begin
                    for (int j = 0; j < N; j++) mrow[j*32 +: 32] = acc[oc-3][j];
                    arr_valid_out <= 1'b1;
                    arr_c <= mrow;
                end else if (oc == 3 + N) begin
                    arr_valid_out <= 1'b1;
                    arr_c <= {N{32'hDEAD_BEEF}};
                end else begin
                    arr_valid_out <= 1'b0;
                    arr_c <= '0;
                    if (oc > 3 + N) oc = 0;
                end
            end
            if (arr_valid_in) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        acc[i][j] += $signed(arr_a[i*DW +: DW]) * $signed(arr_b[j*DW +: DW]);
                beats++;
                if (beats == N) begin
                    beats = 0;
                    if (!tie_off) oc = 1;
                end
            end
        end
    end

    // Passive monitor, sampled on the falling edge.
    int run = 0, feed_runs = 0, last_run = 0, rlow = 0, last_rlow = 0, xfers = 0, ov_cycles = 0;
    logic prev_vin = 1'b0, prev_ov = 1'b0, prev_or = 1'b0, prev_last = 1'b0;
    logic [RW-1:0] prev_row = '0;
    logic [AW-1:0] feed_a [N];
    logic [AW-1:0] feed_b [N];
    always @(negedge clk) begin
        if (!arr_rst_n) rlow++;
        else if (rlow > 0) begin
            last_rlow = rlow;
            rlow = 0;
        end
        if (arr_valid_in) begin
            if (!prev_vin) check("clear_pulse_len", 64'(last_rlow), 64'd1);
            if (run < N) begin
                feed_a[run] = arr_a;
                feed_b[run] = arr_b;
            end
            run++;
        end else if (prev_vin) begin
            last_run = run;
            feed_runs++;
            run = 0;
        end
        if (prev_ov && !prev_or) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_row", out_row, prev_row);
            check("hold_last", out_last, prev_last);
        end
        check("ready_vs_busy", in_ready && busy, 1'b0);
        if (out_valid) ov_cycles++;
        if (out_valid && out_ready) xfers++;
        prev_vin  = arr_valid_in;
        prev_ov   = out_valid;
        prev_or   = out_ready;
        prev_row  = out_row;
        prev_last = out_last;
    end

    typedef struct {
        logic [N-1:0][AW-1:0] a;
        logic [N-1:0][AW-1:0] b;
        logic [N-1:0][RW-1:0] row;
        bit                   gap;
        int                   stall;
    } job_t;
    job_t jobs [4];

    task automatic check_reset_vals();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_row", out_row, 64'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_arr_rst_n", arr_rst_n, 1'b0);
        check("rst_arr_valid_in", arr_valid_in, 1'b0);
        check("rst_arr_a", arr_a, 64'd0);
        check("rst_arr_b", arr_b, 64'd0);
    endtask

    task automatic send_beat(input logic [AW-1:0] a, input logic [AW-1:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("in_ready_wait", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
    endtask

    task automatic recv_rows(input job_t j);
        for (int r = 0; r < N; r++) begin
            int n = 0;
            while (!out_valid && n < 300) begin
                tick();
                n++;
            end
            check("row_valid", out_valid, 1'b1);
            check("row_data", out_row, j.row[r]);
            check("row_last", out_last, (r == N - 1));
            if (r == 0 && j.stall > 0) begin
                repeat (j.stall) begin
                    tick();
                    check("stall_in_ready", in_ready, 1'b0);
                end
                check("stall_row", out_row, j.row[0]);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check("done_valid", out_valid, 1'b0);
        check("done_in_ready", in_ready, 1'b1);
        check("done_busy", busy, 1'b0);
    endtask

    task automatic run_job(input job_t j);
        int x0 = xfers;
        int f0 = feed_runs;
        for (int k = 0; k < N; k++) begin
            send_beat(j.a[k], j.b[k]);
            if (j.gap && k == 0) repeat (2) tick();
        end
        recv_rows(j);
        repeat (6) tick();
        check("xfer_count", 64'(xfers - x0), 64'(N));
        check("feed_runs", 64'(feed_runs - f0), 64'd1);
        check("feed_len", 64'(last_run), 64'(N));
        for (int k = 0; k < N; k++) begin
            check("feed_a", feed_a[k], j.a[k]);
            check("feed_b", feed_b[k], j.b[k]);
        end
    endtask

    initial begin
        int n;
        int o0;

        // Beat k: a slice i = A[i][k], b slice j = B[k][j]; row r slice j = C[r][j].
        jobs[0].a[0] = {16'sd3, 16'sd1};
        jobs[0].b[0] = {16'sd6, 16'sd5};
        jobs[0].a[1] = {16'sd4, 16'sd2};
        jobs[0].b[1] = {16'sd8, 16'sd7};
        jobs[0].row[0] = {32'sd22, 32'sd19};
        jobs[0].row[1] = {32'sd50, 32'sd43};
        jobs[0].gap = 1'b0;
        jobs[0].stall = 0;
        jobs[1] = jobs[0];
        jobs[2] = jobs[0];
        jobs[2].gap = 1'b1;
        jobs[2].stall = 5;
        jobs[3].a[0] = {16'sd3, -16'sd1};
        jobs[3].b[0] = {-16'sd6, 16'sd5};
        jobs[3].a[1] = {-16'sd4, 16'sd2};
        jobs[3].b[1] = {16'sd8, -16'sd7};
        jobs[3].row[0] = {32'sd22, -32'sd19};
        jobs[3].row[1] = {-32'sd50, 32'sd43};
        jobs[3].gap = 1'b0;
        jobs[3].stall = 0;

        #2 rst_n = 1'b0;
        repeat (3) tick();
        check_reset_vals();
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready_low", in_ready, 1'b0);
        tick();
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_arr_rst_n", arr_rst_n, 1'b1);

        for (int v = 0; v < 4; v++) run_job(jobs[v]);

        // Timeout: the array never answers.
        tie_off = 1'b1;
        send_beat(jobs[0].a[0], jobs[0].b[0]);
        send_beat(jobs[0].a[1], jobs[0].b[1]);
        n = 0;
        while (!arr_valid_in && n < 50) begin tick(); n++; end
        check("to_feed_seen", arr_valid_in, 1'b1);
        n = 0;
        while (arr_valid_in && n < 50) begin tick(); n++; end
        check("to_wait_seen", arr_valid_in, 1'b0);
        n = 0;
        while (!err && n < 200) begin tick(); n++; end
        check("to_cycles", 64'(n), 64'(WT));
        check("to_err", err, 1'b1);
        check("to_arr_rst_low", arr_rst_n, 1'b0);
        check("to_in_ready", in_ready, 1'b1);
        check("to_busy", busy, 1'b0);
        tick();
        check("to_arr_rst_high", arr_rst_n, 1'b1);
        check("to_err_sticky", err, 1'b1);
        tie_off = 1'b0;
        send_beat(jobs[0].a[0], jobs[0].b[0]);
        check("to_err_cleared", err, 1'b0);
        send_beat(jobs[0].a[1], jobs[0].b[1]);
        recv_rows(jobs[0]);

        // Reset during the second FEED cycle.
        send_beat(jobs[3].a[0], jobs[3].b[0]);
        send_beat(jobs[3].a[1], jobs[3].b[1]);
        n = 0;
        while (!arr_valid_in && n < 50) begin tick(); n++; end
        tick();
        check("rf_in_feed", arr_valid_in, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        o0 = ov_cycles;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        check("rf_arr_rst_n_low", arr_rst_n, 1'b0);
        tick();
        check("rf_in_ready", in_ready, 1'b1);
        check("rf_arr_rst_n", arr_rst_n, 1'b1);
        repeat (20) tick();
        check("rf_no_output", 64'(ov_cycles - o0), 64'd0);
        run_job(jobs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
